// File: rtl/ahb_bus_arbiter_if.sv
// Arbitration signals shared between the AHB masters and the bus arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters' side.
interface ahb_bus_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int MASTER_W    = 2
);
  logic [NUM_MASTERS-1:0] HBUSREQ;
  logic [NUM_MASTERS-1:0] HLOCK;
  logic [1:0]             HTRANS;
  logic [2:0]             HBURST;
  logic                   HREADY;
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [MASTER_W-1:0]    HMASTER;
  logic                   HMASTLOCK;

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
    input  HGRANT, HMASTER, HMASTLOCK
  );

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
    output HGRANT, HMASTER, HMASTLOCK
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter: never splits a fixed-length burst, holds the grant for a
// locked owner, and hands the address phase over one accepted cycle after HGRANT moves.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int MASTER_W       = 2,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic HCLK,
  input  logic HRESET,
  ahb_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ARB, BURST, BURST_U} state_e;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;
  localparam logic [2:0] HB_SINGLE = 3'b000;
  localparam logic [2:0] HB_INCR   = 3'b001;

  state_e                 state_q;
  logic [4:0]             beat_cnt_q;
  logic [4:0]             burst_len_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [MASTER_W-1:0]    owner_q;
  logic [MASTER_W-1:0]    hmaster_q;
  logic                   hmastlock_q;
  logic [MASTER_W-1:0]    owner_d;
  logic                   do_rearb;

  function automatic logic [4:0] burst_len(input logic [2:0] hburst);
    case (hburst[2:1])
      2'b01:   return 5'd4;
      2'b10:   return 5'd8;
      2'b11:   return 5'd16;
      default: return 5'd1;
    endcase
  endfunction

  function automatic logic [MASTER_W-1:0] wrap_idx(input logic [MASTER_W-1:0] base,
                                                   input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NUM_MASTERS) sum = sum - NUM_MASTERS;
    return MASTER_W'(sum);
  endfunction

  // Scan from lowest to highest priority so the nearest requester after the owner wins.
  always_comb begin
    owner_d = MASTER_W'(DEFAULT_MASTER);
    if (bus.HLOCK[owner_q] && bus.HBUSREQ[owner_q]) begin
      owner_d = owner_q;
    end else begin
      for (int i = NUM_MASTERS; i >= 1; i--) begin
        if (bus.HBUSREQ[wrap_idx(owner_q, i)]) owner_d = wrap_idx(owner_q, i);
      end
    end
  end

  always_comb begin
    // NOTE: assign a default before the case so every path drives do_rearb and no latch is inferred.
    do_rearb = 1'b0;
    case (state_q)
      ARB:     do_rearb = !(bus.HTRANS == HT_NONSEQ && bus.HBURST != HB_SINGLE);
      BURST:   do_rearb = (bus.HTRANS == HT_SEQ && beat_cnt_q == burst_len_q - 5'd1) ||
                          bus.HTRANS == HT_IDLE || bus.HTRANS == HT_NONSEQ;
      BURST_U: do_rearb = bus.HTRANS == HT_IDLE || bus.HTRANS == HT_NONSEQ;
      default: do_rearb = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ARB;
      beat_cnt_q  <= '0;
      burst_len_q <= 5'd1;
      owner_q     <= MASTER_W'(DEFAULT_MASTER);
      grant_q     <= NUM_MASTERS'(1) << DEFAULT_MASTER;
      hmaster_q   <= MASTER_W'(DEFAULT_MASTER);
      hmastlock_q <= 1'b0;
    end else if (bus.HREADY) begin
      hmaster_q   <= owner_q;
      hmastlock_q <= bus.HLOCK[owner_q];
      if (do_rearb) begin
        owner_q <= owner_d;
        grant_q <= NUM_MASTERS'(1) << owner_d;
      end
      case (state_q)
        ARB: begin
          if (bus.HTRANS == HT_NONSEQ && bus.HBURST == HB_INCR) begin
            state_q <= BURST_U;
          end else if (bus.HTRANS == HT_NONSEQ && bus.HBURST != HB_SINGLE) begin
            state_q     <= BURST;
            beat_cnt_q  <= 5'd1;
            burst_len_q <= burst_len(bus.HBURST);
          end
        end
        BURST: begin
          if (do_rearb) begin
            state_q    <= ARB;
            beat_cnt_q <= '0;
          end else if (bus.HTRANS == HT_SEQ) begin
            beat_cnt_q <= beat_cnt_q + 5'd1;
          end
        end
        BURST_U: if (do_rearb) state_q <= ARB;
        default: begin
          state_q    <= ARB;
          beat_cnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.HGRANT    = grant_q;
  assign bus.HMASTER   = hmaster_q;
  assign bus.HMASTLOCK = hmastlock_q;

endmodule
